// File: rtl/cntr_pkg.sv
// Shared types for the down_timer block: FSM state encoding and width limits.
package cntr_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam int unsigned MinWidth = 2;

    function automatic logic state_is_busy(input state_e s);
        return (s == StRun) || (s == StPause);
    endfunction

endpackage

// File: rtl/dec_cntr.sv
// Loadable WIDTH-bit down counter with synchronous reset; saturates at zero.
module dec_cntr #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;

    // Decrement is gated on non-zero so the counter can never wrap.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - One;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/down_timer.sv
// Countdown timer: IDLE/RUN/PAUSE/DONE control FSM driving a dec_cntr datapath.
module down_timer
    import cntr_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_start,
    input  logic             i_pause,
    input  logic             i_stop,
    output logic [WIDTH-1:0] o_count,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_zero
);

    localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           r_state;
    state_e           w_state_next;
    logic             r_busy;
    logic             r_done;
    logic             w_load;
    logic             w_dec;
    logic [WIDTH-1:0] w_count;

    dec_cntr #(
        .WIDTH(WIDTH)
    ) u_dec_cntr (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_load),
        .i_load_val (i_load_val),
        .i_dec      (w_dec),
        .o_count    (w_count)
    );

    // Priority stop > pause > start > load; in IDLE stop/pause mask start and load.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_dec        = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!i_stop && !i_pause) begin
                    if (i_start) begin
                        w_state_next = (w_count == '0) ? StDone : StRun;
                    end else if (i_load) begin
                        w_load = 1'b1;
                    end
                end
            end
            StRun: begin
                if (i_stop) begin
                    w_state_next = StIdle;
                end else if (i_pause) begin
                    w_state_next = StPause;
                end else begin
                    w_dec = 1'b1;
                    if (w_count == One) begin
                        w_state_next = StDone;
                    end
                end
            end
            StPause: begin
                if (i_stop) begin
                    w_state_next = StIdle;
                end else if (!i_pause && i_start) begin
                    w_state_next = StRun;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // busy/done are flopped alongside the state so they cannot glitch on encoding changes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= state_is_busy(w_state_next);
            r_done  <= (w_state_next == StDone);
        end
    end

    assign o_count = w_count;
    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_zero  = (w_count == '0);

endmodule
